// File: rtl/epu_layer_sequencer.sv
// Layer command sequencer feeding the EPU bus switcher: queues layer commands and
// walks each through select/start/run/drain while holding a one-hot bus mode.
module epu_layer_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned TO_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_type,
    input  logic [TO_W-1:0] timeout_limit,
    output logic [3:0]      mode,
    output logic            conv_3x3_en,
    output logic            conv_1x1_en,
    output logic            maxpool_en,
    output logic            unit_start,
    input  logic            conv_3x3_done,
    input  logic            conv_1x1_done,
    input  logic            maxpool_done,
    output logic            layer_done,
    output logic            busy,
    output logic            err,
    input  logic            err_clr
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [1:0]      cur, cur_nxt;
    logic [1:0]      head;
    logic [GW-1:0]   guard, guard_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            push, pop, err_set, done_sel, layer_done_nxt, err_nxt;
    logic [3:0]      mode_nxt;

    assign head = fifo_mem[rd_ptr];

    // Next-state, FIFO bookkeeping and next values of every registered output
    always_comb begin
        state_nxt      = state;
        cur_nxt        = cur;
        guard_nxt      = guard;
        to_cnt_nxt     = to_cnt;
        pop            = 1'b0;
        err_set        = 1'b0;
        layer_done_nxt = 1'b0;
        push           = cmd_valid && cmd_ready;

        done_sel = 1'b0;
        case (cur)
            2'd0:    done_sel = conv_3x3_done;
            2'd1:    done_sel = conv_1x1_done;
            2'd2:    done_sel = maxpool_done;
            default: done_sel = 1'b0;
        endcase

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    cur_nxt = head;
                    if (head == 2'd3) begin
                        err_set = 1'b1;
                    end else begin
                        state_nxt = S_SETUP;
                        guard_nxt = GW'(GUARD_CYCLES - 1);
                    end
                end
            end
            S_SETUP: begin
                if (guard == '0) state_nxt = S_START;
                else             guard_nxt = guard - GW'(1);
            end
            S_START: begin
                to_cnt_nxt = '0;
                state_nxt  = S_RUN;
            end
            S_RUN: begin
                // Done beats a simultaneous timeout and leaves err untouched
                if (done_sel) begin
                    state_nxt = S_DRAIN;
                    guard_nxt = GW'(GUARD_CYCLES - 1);
                end else if (timeout_limit != '0 && to_cnt == timeout_limit - TO_W'(1)) begin
                    err_set   = 1'b1;
                    state_nxt = S_DRAIN;
                    guard_nxt = GW'(GUARD_CYCLES - 1);
                end else if (to_cnt != '1) begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            S_DRAIN: begin
                if (guard == '0) begin
                    state_nxt      = S_IDLE;
                    layer_done_nxt = 1'b1;
                end else begin
                    guard_nxt = guard - GW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        count_nxt = count;
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (!push && pop) count_nxt = count - CW'(1);

        mode_nxt = 4'b0001;
        if (state_nxt != S_IDLE) begin
            case (cur_nxt)
                2'd0:    mode_nxt = 4'b0010;
                2'd1:    mode_nxt = 4'b0100;
                2'd2:    mode_nxt = 4'b1000;
                default: mode_nxt = 4'b0001;
            endcase
        end

        err_nxt = err;
        if (err_set)      err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur         <= 2'd0;
            guard       <= '0;
            to_cnt      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mode        <= 4'b0001;
            conv_3x3_en <= 1'b0;
            conv_1x1_en <= 1'b0;
            maxpool_en  <= 1'b0;
            unit_start  <= 1'b0;
            layer_done  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            cmd_ready   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur         <= cur_nxt;
            guard       <= guard_nxt;
            to_cnt      <= to_cnt_nxt;
            count       <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            mode        <= mode_nxt;
            conv_3x3_en <= mode_nxt[1];
            conv_1x1_en <= mode_nxt[2];
            maxpool_en  <= mode_nxt[3];
            unit_start  <= (state_nxt == S_START);
            layer_done  <= layer_done_nxt;
            busy        <= (state_nxt != S_IDLE) || (count_nxt != '0);
            err         <= err_nxt;
            cmd_ready   <= (count_nxt != CW'(FIFO_DEPTH));
        end
    end

    // Command storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cmd_type;
    end

endmodule
